handshake_const_check_sink: RTL and testbench

- Receiving end of the constant-producer dataflow channel: consumes data tokens and compares each against a parameterised expected constant.
- Emits one control token per consumed data token, carrying a match flag.
- Keeps saturating match/mismatch counters and a sticky error flag for on-chip self-check.
- Two-entry elastic buffer gives full throughput, one-cycle latency and a registered ins_ready.

---
 rtl/handshake_pkg.sv | 18 +
 rtl/handshake_tehb2.sv | 81 ++++++++
 rtl/handshake_const_check_sink.sv | 77 +++++++
 tb/tb_handshake_const_check_sink.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake constant-check blocks: the state
// encoding of the elastic buffer and a saturating counter increment.
package handshake_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // Increment v, clamping at 2^w-1; callers truncate the result to w bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_val;
    max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= max_val) ? max_val : v + 64'd1;
  endfunction

endpackage

// File: rtl/handshake_tehb2.sv
// Two-entry ready/valid elastic buffer: full throughput, one-cycle latency,
// and an in_ready that comes straight from a flop.
module handshake_tehb2
  import handshake_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         accept, emit;

  assign in_ready  = ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_q;
  assign accept    = in_valid & ready_q;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = in_data;
        end
      end
      ST_ONE: begin
        if (accept && !emit) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (!accept && emit) begin
          state_d = ST_EMPTY;
        end else if (accept && emit) begin
          out_d = in_data;
        end
      end
      ST_TWO: begin
        if (emit) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Ready for the next cycle is decided from the next state only, so there
    // is no combinational path from out_ready to in_ready.
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

  // The skid entry is only read in ST_TWO, so it needs no reset value.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: rtl/handshake_const_check_sink.sv
// Consumes data tokens, compares each against EXPECTED and emits one match
// token per input, while keeping saturating match/mismatch statistics.
module handshake_const_check_sink
  import handshake_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED   = DATA_WIDTH'(32'h0DF66055),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  ctrl_match,
  output logic                  ctrl_valid,
  input  logic                  ctrl_ready,
  input  logic                  clear,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  error_sticky
);

  logic                 is_match;
  logic                 accept;
  logic [CNT_WIDTH-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_WIDTH-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic                 err_q, err_d;

  assign is_match = (ins == EXPECTED);
  assign accept   = ins_valid & ins_ready;

  handshake_tehb2 #(
    .W(1)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst),
    .in_data  (is_match),
    .in_valid (ins_valid),
    .in_ready (ins_ready),
    .out_data (ctrl_match),
    .out_valid(ctrl_valid),
    .out_ready(ctrl_ready)
  );

  // Clear zeroes the statistics first; a concurrent accept then counts on top.
  always_comb begin
    match_cnt_d    = clear ? '0 : match_cnt_q;
    mismatch_cnt_d = clear ? '0 : mismatch_cnt_q;
    err_d          = clear ? 1'b0 : err_q;
    if (accept) begin
      if (is_match) begin
        match_cnt_d = CNT_WIDTH'(sat_inc(64'(match_cnt_d), CNT_WIDTH));
      end else begin
        mismatch_cnt_d = CNT_WIDTH'(sat_inc(64'(mismatch_cnt_d), CNT_WIDTH));
        err_d          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      err_q          <= 1'b0;
    end else begin
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      err_q          <= err_d;
    end
  end

  assign match_count    = match_cnt_q;
  assign mismatch_count = mismatch_cnt_q;
  assign error_sticky   = err_q;

endmodule

// File: tb/tb_handshake_const_check_sink.sv
// Directed, table-driven and scoreboard checks for handshake_const_check_sink.
module tb_handshake_const_check_sink;

  localparam logic [31:0] E = 32'h0DF66055;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        ctrl_ready = 1'b0;
  logic        clear = 1'b0;

  logic        ins_ready, ctrl_match, ctrl_valid, error_sticky;
  logic [15:0] match_count, mismatch_count;
  logic        ins_ready4, ctrl_match4, ctrl_valid4, error_sticky4;
  logic [3:0]  match_count4, mismatch_count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  handshake_const_check_sink dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ctrl_match(ctrl_match), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .clear(clear), .match_count(match_count), .mismatch_count(mismatch_count),
    .error_sticky(error_sticky)
  );

  handshake_const_check_sink #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
    .ctrl_match(ctrl_match4), .ctrl_valid(ctrl_valid4), .ctrl_ready(ctrl_ready),
    .clear(clear), .match_count(match_count4), .mismatch_count(mismatch_count4),
    .error_sticky(error_sticky4)
  );

  typedef struct {
    logic [31:0] ins;
    logic        v;
    logic        cr;
    logic        clr;
    logic        e_valid;
    logic        e_match;
    logic        e_ready;
    logic [15:0] e_mc;
    logic [15:0] e_mm;
    logic        e_err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ins_valid = 1'b0;
    ctrl_ready = 1'b0;
    clear = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      ins        = vecs[i].ins;
      ins_valid  = vecs[i].v;
      ctrl_ready = vecs[i].cr;
      clear      = vecs[i].clr;
      step();
      check($sformatf("v%0d_valid", i), 32'(ctrl_valid), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid)
        check($sformatf("v%0d_match", i), 32'(ctrl_match), 32'(vecs[i].e_match));
      check($sformatf("v%0d_ready", i), 32'(ins_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_mcnt", i), 32'(match_count), 32'(vecs[i].e_mc));
      check($sformatf("v%0d_mmcnt", i), 32'(mismatch_count), 32'(vecs[i].e_mm));
      check($sformatf("v%0d_err", i), 32'(error_sticky), 32'(vecs[i].e_err));
    end
    ins_valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    bit          exp_q[$];
    bit          exp_bit;
    int          accepted;
    int          cycles;
    int          emits;

    //           ins  v  cr clr  ev em er  mc     mm     err
    vecs[0]  = '{E,  1, 1, 0,   1, 1, 1,  16'd1, 16'd0, 0};
    vecs[1]  = '{E,  1, 1, 0,   1, 1, 1,  16'd2, 16'd0, 0};
    vecs[2]  = '{E,  1, 1, 0,   1, 1, 1,  16'd3, 16'd0, 0};
    vecs[3]  = '{E,  1, 1, 0,   1, 1, 1,  16'd4, 16'd0, 0};
    vecs[4]  = '{'0, 0, 1, 0,   0, 0, 1,  16'd4, 16'd0, 0};
    vecs[5]  = '{E,  1, 1, 0,   1, 1, 1,  16'd5, 16'd0, 0};
    vecs[6]  = '{'0, 1, 1, 0,   1, 0, 1,  16'd5, 16'd1, 1};
    vecs[7]  = '{E,  1, 1, 0,   1, 1, 1,  16'd6, 16'd1, 1};
    vecs[8]  = '{'0, 0, 1, 0,   0, 0, 1,  16'd6, 16'd1, 1};
    vecs[9]  = '{E,  1, 0, 0,   1, 1, 1,  16'd7, 16'd1, 1};
    vecs[10] = '{'0, 1, 0, 0,   1, 1, 0,  16'd7, 16'd2, 1};
    vecs[11] = '{E,  1, 0, 0,   1, 1, 0,  16'd7, 16'd2, 1};
    vecs[12] = '{E,  0, 1, 0,   1, 0, 1,  16'd7, 16'd2, 1};
    vecs[13] = '{'0, 0, 1, 0,   0, 0, 1,  16'd7, 16'd2, 1};
    vecs[14] = '{'0, 0, 1, 1,   0, 0, 1,  16'd0, 16'd0, 0};
    vecs[15] = '{'0, 1, 1, 1,   1, 0, 1,  16'd0, 16'd1, 1};
    vecs[16] = '{'0, 0, 1, 0,   0, 0, 1,  16'd0, 16'd1, 1};

    // Reset values while held in reset
    step();
    check("rst_valid", 32'(ctrl_valid), 32'd0);
    check("rst_match", 32'(ctrl_match), 32'd0);
    check("rst_ready", 32'(ins_ready), 32'd1);
    check("rst_mcnt", 32'(match_count), 32'd0);
    check("rst_mmcnt", 32'(mismatch_count), 32'd0);
    check("rst_err", 32'(error_sticky), 32'd0);
    rst = 1'b1;

    // Back-to-back matches, mixed tokens, sticky hold
    run_vecs(0, 8);
    for (int i = 0; i < 10; i++) step();
    check("sticky_hold", 32'(error_sticky), 32'd1);
    check("sticky_mm", 32'(mismatch_count), 32'd1);

    // Backpressure fill/drain and clear
    run_vecs(9, 16);

    // Saturation on the 4-bit instance, then clear with a mismatching accept
    do_reset();
    ins = E; ins_valid = 1'b1; ctrl_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    ins_valid = 1'b0;
    step();
    check("sat_mcnt4", 32'(match_count4), 32'd15);
    check("sat_mcnt16", 32'(match_count), 32'd20);
    check("sat_mm4", 32'(mismatch_count4), 32'd0);
    step();
    check("sat_hold4", 32'(match_count4), 32'd15);
    ins = 32'h0; ins_valid = 1'b1; clear = 1'b1;
    step();
    ins_valid = 1'b0; clear = 1'b0;
    check("clr_mcnt4", 32'(match_count4), 32'd0);
    check("clr_mm4", 32'(mismatch_count4), 32'd1);
    check("clr_err4", 32'(error_sticky4), 32'd1);
    check("clr_valid4", 32'(ctrl_valid4), 32'd1);
    check("clr_match4", 32'(ctrl_match4), 32'd0);
    check("clr_ready4", 32'(ins_ready4), 32'd1);
    step();

    // Asynchronous reset with the buffer full
    do_reset();
    ins = E; ins_valid = 1'b1; ctrl_ready = 1'b0;
    step();
    step();
    check("full_ready", 32'(ins_ready), 32'd0);
    check("full_mcnt", 32'(match_count), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(ctrl_valid), 32'd0);
    check("arst_ready", 32'(ins_ready), 32'd1);
    check("arst_mcnt", 32'(match_count), 32'd0);
    ins_valid = 1'b0;
    step();
    rst = 1'b1;
    ins = 32'h1; ins_valid = 1'b1; ctrl_ready = 1'b1;
    step();
    ins_valid = 1'b0;
    emits = 0;
    for (int i = 0; i < 5; i++) begin
      if (ctrl_valid && ctrl_ready) emits++;
      step();
    end
    check("arst_emits", 32'(emits), 32'd1);
    check("arst_mm", 32'(mismatch_count), 32'd1);

    // Random handshake against a scoreboard
    do_reset();
    accepted = 0;
    cycles = 0;
    while (accepted < 10000 && cycles < 70000) begin
      ins_valid  = 1'($urandom_range(0, 1));
      ctrl_ready = 1'($urandom_range(0, 1));
      ins        = ($urandom_range(0, 1) == 1) ? E : $urandom;
      if (ins_valid && ins_ready) begin
        exp_q.push_back(ins == E);
        accepted++;
      end
      if (ctrl_valid && ctrl_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_extra_token", 32'(1), 32'(0));
        end else begin
          exp_bit = exp_q.pop_front();
          check("rand_match", 32'(ctrl_match), 32'(exp_bit));
        end
      end
      step();
      cycles++;
    end
    ins_valid = 1'b0;
    ctrl_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ctrl_valid) begin
        if (exp_q.size() == 0) begin
          check("drain_extra_token", 32'(1), 32'(0));
        end else begin
          exp_bit = exp_q.pop_front();
          check("drain_match", 32'(ctrl_match), 32'(exp_bit));
        end
      end
      step();
    end
    check("rand_accepted", 32'(accepted), 32'd10000);
    check("rand_left", 32'(exp_q.size()), 32'd0);
    check("rand_cnt_sum", 32'(match_count) + 32'(mismatch_count), 32'(accepted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
